// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types: funct3 operation encoding, unit state
// encoding and the register-file address width.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_rs1_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_rs2_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared 2*WIDTH accumulator: one shift-add multiply step or one restoring
// divide step per enabled cycle, working on unsigned magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // Multiply: lo holds the multiplier and drains right; divide: lo holds the
    // dividend draining left while quotient bits fill in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? b_q : {WIDTH{1'b0}})};
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi  <= '0;
            lo  <= '0;
            b_q <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a_mag;
            b_q <= b_mag;
        end else if (step) begin
            if (is_div) begin
                hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], div_ge};
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit driving the register file
// write port; busy stalls issue while an operation is in flight.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      rs1_val,
    input  logic [WIDTH-1:0]      rs2_val,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] CALC = ST_CALC;
    localparam logic [1:0] FIX  = ST_FIX;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [CNT_W-1:0]      cnt;
    muldiv_op_e            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  neg_q;
    logic                  rem_neg_q;

    muldiv_op_e            cur_op;
    logic                  a_neg;
    logic                  b_neg;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic                  div_by_zero;
    logic                  overflow;
    logic                  special;
    logic [WIDTH-1:0]      special_res;
    logic                  accept;
    logic [REG_ADDR_W-1:0] dest;

    logic [WIDTH-1:0]      acc_hi;
    logic [WIDTH-1:0]      acc_lo;
    logic [2*WIDTH-1:0]    prod_fix;
    logic [WIDTH-1:0]      quo_fix;
    logic [WIDTH-1:0]      rem_fix;
    logic [WIDTH-1:0]      fix_res;

    // Operand decode at issue; the most negative value negates to itself,
    // which is exactly its unsigned magnitude.
    always_comb begin
        cur_op      = muldiv_op_e'(op);
        a_neg       = op_rs1_signed(cur_op) & rs1_val[WIDTH-1];
        b_neg       = op_rs2_signed(cur_op) & rs2_val[WIDTH-1];
        a_mag       = a_neg ? -rs1_val : rs1_val;
        b_mag       = b_neg ? -rs2_val : rs2_val;
        div_by_zero = op_is_div(cur_op) && (rs2_val == '0);
        overflow    = (cur_op == OP_DIV || cur_op == OP_REM) &&
                      (rs1_val == MOST_NEG) && (rs2_val == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) begin
            special_res = op_is_rem(cur_op) ? rs1_val : '1;
        end else begin
            special_res = op_is_rem(cur_op) ? '0 : rs1_val;
        end
        accept = (state == IDLE) && start && !flush;
        dest   = (state == IDLE) ? rd_addr : rd_q;
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && !special),
        .step   (state == CALC),
        .is_div (op_is_div(op_q)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi     (acc_hi),
        .lo     (acc_lo)
    );

    // Remainder follows the dividend's sign; product and quotient follow the
    // XOR of operand signs.
    always_comb begin
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            OP_REM, OP_REMU:              fix_res = rem_fix;
            default:                      fix_res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = special ? DONE : CALC;
            CALC:    begin
                         if (flush)                 state_n = IDLE;
                         else if (cnt == CNT_LAST)  state_n = FIX;
                     end
            FIX:     state_n = flush ? IDLE : DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing combinational
    // reaches the ports; wr_data/wr_addr only change when a result lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == CALC && state_n == CALC) ? cnt + 1'b1 : '0;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            wr_en <= (state_n == DONE) && (dest != '0);
            if (accept) begin
                op_q      <= cur_op;
                rd_q      <= rd_addr;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
            end
            if (state_n == DONE) begin
                wr_data <= (state == IDLE) ? special_res : fix_res;
                wr_addr <= {{(WIDTH-REG_ADDR_W){1'b0}}, dest};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, flush,
// ignored start and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        we;
        int          due;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_data, input bit special);
        exp_t e;
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        e.data = exp_data;
        e.addr = {27'd0, rd};
        e.we   = (rd != 5'd0);
        e.due  = cyc + (special ? 1 : 34);
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data, input bit special);
        applyStimulus(o, a, b, rd, exp_data, special);
        waitIdle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},    {31'd0, busy},  32'd0);
        checkOutput({tag, "_done"},    {31'd0, done},  32'd0);
        checkOutput({tag, "_wr_en"},   {31'd0, wr_en}, 32'd0);
        checkOutput({tag, "_wr_addr"}, wr_addr,        32'd0);
        checkOutput({tag, "_wr_data"}, wr_data,        32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("wr_data", wr_data, e.data);
                checkOutput("wr_addr", wr_addr, e.addr);
                checkOutput("wr_en", {31'd0, wr_en}, {31'd0, e.we});
                checkOutput("done_cycle", cyc, e.due);
            end
        end
        if (wr_en && !done) begin
            checks++;
            errors++;
            $display("[TB] FAIL stray_wr_en: got wr_en=1 done=0, expected wr_en=0");
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        @(negedge clk);

        // MUL 7 * -3 with cycle-by-cycle busy / wr_en timing
        applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0);
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            checkOutput($sformatf("busy_c%0d", n), {31'd0, busy}, {31'd0, (n <= 34)});
            checkOutput($sformatf("wr_en_c%0d", n), {31'd0, wr_en}, {31'd0, (n == 34)});
        end
        repeat (3) @(negedge clk);
        checkOutput("hold_wr_data", wr_data, 32'hFFFFFFEB);
        checkOutput("hold_wr_addr", wr_addr, 32'd5);

        runOp(3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 1'b0);
        runOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b0);
        runOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1'b0);
        runOp(3'd0, 32'h12345678, 32'd9,        5'd4, 32'hA3D70A38, 1'b0);
        runOp(3'd4, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFD, 1'b0);
        runOp(3'd6, 32'hFFFFFFF9, 32'd2,        5'd7, 32'hFFFFFFFF, 1'b0);
        runOp(3'd4, 32'd7,        32'hFFFFFFFE, 5'd8, 32'hFFFFFFFD, 1'b0);
        runOp(3'd6, 32'd7,        32'hFFFFFFFE, 5'd9, 32'd1,        1'b0);
        runOp(3'd5, 32'd100,      32'd7,        5'd10, 32'd14,      1'b0);
        runOp(3'd7, 32'd100,      32'd7,        5'd11, 32'd2,       1'b0);
        runOp(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,       1'b0);
        runOp(3'd4, 32'h1234,     32'd0,        5'd13, 32'hFFFFFFFF, 1'b1);
        runOp(3'd7, 32'h1234,     32'd0,        5'd14, 32'h1234,    1'b1);
        runOp(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1);
        runOp(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,       1'b1);

        // Start ignored while busy, then flush kills the operation
        c = cyc;
        op = 3'd5; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        op = 3'd4; rs1_val = 32'd1; rs2_val = 32'd0; rd_addr = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("flush_cycle_offset", cyc - c, 32'd10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_done", {31'd0, done}, 32'd0);
        runOp(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, 1'b0);

        // flush together with start in IDLE: start ignored
        op = 3'd4; rs1_val = 32'd5; rs2_val = 32'd0; rd_addr = 5'd23;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_start_idle_done", {31'd0, done}, 32'd0);

        // Reset asserted mid-CALC clears everything and suppresses the write
        op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5; rd_addr = 5'd24; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("midcalc_reset");
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

        // rd = 0: done pulses, wr_en stays low
        runOp(3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit. Consumes the two source operands read from the register file, runs a WIDTH-cycle shift-add multiply or restoring divide, and drives the register file write port (`wr_en`/`wr_addr`/`wr_data`) with the result. Sits beside the ALU in the execute stage and stalls issue via `busy` while an operation is in flight.

## Interface
- `WIDTH`, 32: operand/result width; also width of `wr_addr` so it connects directly to the register file write port.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val`, `rs2_val`  in  WIDTH  operands (register file outputs `a`, `b`).
- `rd_addr`  in  5  destination register.
- `flush`  in  1  abort in-flight operation (pipeline kill).
- `busy`  out  1  high from the cycle after acceptance until the result cycle, inclusive.
- `done`  out  1  one-cycle result pulse.
- `wr_en`  out  1  register file write enable; equals `done` unless `rd_addr` was 0.
- `wr_addr`  out  WIDTH  captured `rd_addr`, zero-extended.
- `wr_data`  out  WIDTH  result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `start`=1 captures `op`, operands, `rd_addr`. Special cases go directly to DONE; all others go to CALC with iteration counter = 0.
- Special cases (RISC-V semantics, no trap): divisor 0 → DIV/DIVU quotient all ones, REM/REMU remainder = dividend. Signed overflow (DIV/REM, dividend = most negative, divisor = −1) → quotient = dividend, remainder 0.
- Multiply: operands converted to magnitudes per signedness (MUL/MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU both unsigned); 2·WIDTH-bit shift-add accumulate, one bit per cycle.
- Divide: magnitudes (signed for DIV/REM), restoring division, one quotient bit per cycle.
- CALC: exactly WIDTH cycles (counter 0..WIDTH−1), then FIX.
- FIX: sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend's sign. Select low half (MUL), high half (MULH*), quotient, or remainder. → DONE.
- DONE: `done`=1, `wr_en`=(`rd_addr`≠0), `wr_data`/`wr_addr` valid. → IDLE unconditionally.
- `start` while not IDLE: ignored, not queued.
- `flush`=1 in any non-IDLE state: next state IDLE, no `done`/`wr_en` for that operation; `flush` in DONE cycle does not retract that cycle's write. `flush` and `start` together in IDLE: `start` ignored.
- `rst`=0: next edge forces IDLE, counter 0; overrides `flush`/`start`, including mid-CALC.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- All outputs registered/state-decoded; no combinational input→output path.
- Start accepted at edge T. Normal op: CALC T+1..T+WIDTH, FIX T+WIDTH+1, DONE (write) T+WIDTH+2 → 34 cycles at WIDTH=32. Special case: DONE at T+1.
- `busy` high T+1 through DONE cycle; new `start` accepted in the cycle after DONE.
- `wr_data`/`wr_addr` hold last values outside DONE; only `wr_en` qualifies them.

## Structure
- Shared package `riscv_pkg`: `muldiv_op_e` enum (funct3 encoding above), `muldiv_state_e` enum, `REG_ADDR_W = 5`.
- One sub-module natural: `muldiv_iter` — shared 2·WIDTH accumulator/shift datapath performing one multiply or restoring-divide step per enabled cycle; FSM, sign handling and result select stay in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5, start at T → `wr_en`=1 only at T+34, `wr_data`=0xFFFFFFEB, `wr_addr`=5, `busy` high T+1..T+34.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- DIV 0x1234/0 → 0xFFFFFFFF, REMU 0x1234/0 → 0x1234, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; each written at T+1.
- `start` pulsed at T+5 while busy → ignored; `flush` at T+10 → IDLE at T+11, no `done`; fresh start at T+11 completes normally.
- `rst`=0 at T+20 mid-CALC → all outputs 0 next edge, no write; MUL with rd=0 → `done` pulses, `wr_en` stays 0.
